// File: rtl/echo_delay_line.sv
// Stereo programmable echo: per-frame read of a delayed sample, write back input + feedback, output dry + wet.
// Latency: outputs and out_valid appear 5 cycles after the frame start is detected (1 cycle when the frame lands during the clear).
// Backpressure: none; a frame start that arrives mid-frame is dropped and latches the sticky overrun flag.
module echo_delay_line #(
    parameter int DATALEN = 16,
    parameter int ADDRLEN = 14
) (
    input  logic               bclk,
    input  logic               resetn,
    input  logic               lrclk,
    input  logic [DATALEN-1:0] left_in,
    input  logic [DATALEN-1:0] right_in,
    input  logic [ADDRLEN-1:0] delay_len,
    input  logic [3:0]         fb_shift,
    input  logic [3:0]         wet_shift,
    input  logic               bypass,
    output logic [DATALEN-1:0] left_out,
    output logic [DATALEN-1:0] right_out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int                 RAM_DEPTH = 2 ** (ADDRLEN + 1);
    localparam logic [ADDRLEN:0]   CLR_LAST  = '1;
    localparam logic [ADDRLEN:0]   CLR_ONE   = {{ADDRLEN{1'b0}}, 1'b1};
    localparam logic [ADDRLEN-1:0] PTR_ONE   = {{(ADDRLEN-1){1'b0}}, 1'b1};
    localparam logic [DATALEN-1:0] SAT_MAX   = {1'b0, {(DATALEN-1){1'b1}}};
    localparam logic [DATALEN-1:0] SAT_MIN   = {1'b1, {(DATALEN-1){1'b0}}};

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        IDLE  = 3'd1,
        RDL   = 3'd2,
        RDR   = 3'd3,
        WRL   = 3'd4,
        WRR   = 3'd5
    } state_t;

    // x + (d >>> sh), evaluated one bit wider and clamped to the sample range; sh = 15 removes the term.
    function automatic logic [DATALEN-1:0] sat_add(input logic [DATALEN-1:0] x,
                                                   input logic [DATALEN-1:0] d,
                                                   input logic [3:0]         sh);
        logic signed [DATALEN-1:0] ds;
        logic signed [DATALEN-1:0] shifted;
        logic [DATALEN:0]          sum;
        ds = d;
        if (sh == 4'd15) begin
            shifted = '0;
        end else begin
            shifted = ds >>> sh;
        end
        sum = {x[DATALEN-1], x} + {shifted[DATALEN-1], shifted};
        if (sum[DATALEN] != sum[DATALEN-1]) begin
            return sum[DATALEN] ? SAT_MIN : SAT_MAX;
        end
        return sum[DATALEN-1:0];
    endfunction

    // State and datapath registers
    state_t             state_q, state_d;
    logic [ADDRLEN:0]   clr_addr_q, clr_addr_d;
    logic [ADDRLEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRLEN-1:0] dly_q, dly_d;
    logic [3:0]         fb_q, fb_d;
    logic [3:0]         wet_q, wet_d;
    logic               byp_q, byp_d;
    logic [DATALEN-1:0] xl_q, xl_d;
    logic [DATALEN-1:0] xr_q, xr_d;
    logic [DATALEN-1:0] dl_q, dl_d;
    logic [DATALEN-1:0] dr_q, dr_d;
    logic [DATALEN-1:0] left_out_q, left_out_d;
    logic [DATALEN-1:0] right_out_q, right_out_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               sync3_q, sync3_d;

    // Buffer port
    logic [DATALEN-1:0] mem [RAM_DEPTH];
    logic [DATALEN-1:0] ram_rdata;
    logic               ram_we;
    logic [ADDRLEN:0]   ram_addr;
    logic [DATALEN-1:0] ram_wdata;

    logic               frame_start;
    logic [ADDRLEN-1:0] rd_ptr;
    logic [DATALEN-1:0] wl_word, wr_word, yl_word, yr_word;

    assign frame_start = sync2_q & ~sync3_q;
    assign rd_ptr      = wr_ptr_q - dly_q;

    // Per-channel stored word (feedback path) and output word (wet path or bypass)
    always_comb begin
        wl_word = sat_add(xl_q, dl_q, fb_q);
        wr_word = sat_add(xr_q, dr_q, fb_q);
        yl_word = byp_q ? xl_q : sat_add(xl_q, dl_q, wet_q);
        yr_word = byp_q ? xr_q : sat_add(xr_q, dr_q, wet_q);
    end

    // Next-state logic: clear sweep, frame sequencing and buffer port arbitration
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        wr_ptr_d    = wr_ptr_q;
        dly_d       = dly_q;
        fb_d        = fb_q;
        wet_d       = wet_q;
        byp_d       = byp_q;
        xl_d        = xl_q;
        xr_d        = xr_q;
        dl_d        = dl_q;
        dr_d        = dr_q;
        left_out_d  = left_out_q;
        right_out_d = right_out_q;
        out_valid_d = 1'b0;
        busy_d      = (state_q == CLEAR);
        overrun_d   = overrun_q;
        sync1_d     = lrclk;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;

        case (state_q)
            CLEAR: begin
                ram_we     = 1'b1;
                ram_addr   = clr_addr_q;
                clr_addr_d = clr_addr_q + CLR_ONE;
                if (clr_addr_q == CLR_LAST) begin
                    state_d = IDLE;
                end
                // The buffer is not usable yet, so the frame passes straight through.
                if (frame_start) begin
                    left_out_d  = left_in;
                    right_out_d = right_in;
                    out_valid_d = 1'b1;
                end
            end
            IDLE: begin
                if (frame_start) begin
                    xl_d    = left_in;
                    xr_d    = right_in;
                    dly_d   = (delay_len == '0) ? PTR_ONE : delay_len;
                    fb_d    = fb_shift;
                    wet_d   = wet_shift;
                    byp_d   = bypass;
                    state_d = RDL;
                end
            end
            RDL: begin
                ram_addr = {1'b0, rd_ptr};
                state_d  = RDR;
            end
            RDR: begin
                ram_addr = {1'b1, rd_ptr};
                dl_d     = ram_rdata;
                state_d  = WRL;
            end
            WRL: begin
                ram_we    = 1'b1;
                ram_addr  = {1'b0, wr_ptr_q};
                ram_wdata = wl_word;
                dr_d      = ram_rdata;
                state_d   = WRR;
            end
            WRR: begin
                ram_we      = 1'b1;
                ram_addr    = {1'b1, wr_ptr_q};
                ram_wdata   = wr_word;
                left_out_d  = yl_word;
                right_out_d = yr_word;
                out_valid_d = 1'b1;
                wr_ptr_d    = wr_ptr_q + PTR_ONE;
                state_d     = IDLE;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        // A frame start mid-frame is dropped; the running frame still completes.
        if (frame_start && (state_q != IDLE) && (state_q != CLEAR)) begin
            overrun_d = 1'b1;
        end
    end

    // Control and datapath registers; reset restarts the clear from address 0
    always_ff @(posedge bclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            wr_ptr_q    <= '0;
            dly_q       <= PTR_ONE;
            fb_q        <= 4'd15;
            wet_q       <= 4'd15;
            byp_q       <= 1'b0;
            xl_q        <= '0;
            xr_q        <= '0;
            dl_q        <= '0;
            dr_q        <= '0;
            left_out_q  <= '0;
            right_out_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            dly_q       <= dly_d;
            fb_q        <= fb_d;
            wet_q       <= wet_d;
            byp_q       <= byp_d;
            xl_q        <= xl_d;
            xr_q        <= xr_d;
            dl_q        <= dl_d;
            dr_q        <= dr_d;
            left_out_q  <= left_out_d;
            right_out_q <= right_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
        end
    end

    // Single-port buffer: one access per cycle, read data one cycle after the address
    always_ff @(posedge bclk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    assign left_out  = left_out_q;
    assign right_out = right_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule
